// File: rtl/konami_audio_pkg.sv
// Shared types and helpers for the Konami audio mixer: FSM states,
// accumulator sizing, gain decode/shift and the output clamp.
package konami_audio_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } mix_state_t;

    // Working widths for the helpers; large enough for IN_W up to 32.
    localparam int SCALE_W = 40;
    localparam int SAT_W   = 48;

    localparam logic signed [SAT_W-1:0] SAT_ONE = SAT_W'(1);

    typedef struct packed {
        logic signed [31:0] value;
        logic               clip;
    } sat_t;

    // Sign bit, up to 7 bits of gain headroom, and log2(CHANNELS) bits of sum growth.
    function automatic int acc_width(input int in_w, input int channels);
        return in_w + 1 + 7 + $clog2(channels);
    endfunction

    // Gain code -8..7: non-negative shifts left, negative shifts right arithmetically.
    function automatic logic signed [SCALE_W-1:0] gain_scale(
        input logic signed [SCALE_W-1:0] x,
        input logic signed [3:0]         g
    );
        logic [3:0] mag;
        mag = ~g + 4'd1;
        if (!g[3]) begin
            return x <<< g[2:0];
        end
        return x >>> mag;
    endfunction

    function automatic sat_t saturate(
        input logic signed [SAT_W-1:0] v,
        input int                      out_w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sat_t r;
        hi = (SAT_ONE <<< (out_w - 1)) - SAT_ONE;
        lo = ~hi;
        if (v > hi) begin
            r.value = hi[31:0];
            r.clip  = 1'b1;
        end else if (v < lo) begin
            r.value = lo[31:0];
            r.clip  = 1'b1;
        end else begin
            r.value = v[31:0];
            r.clip  = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/konami_audio_mixer_if.sv
// Sample-strobe, channel-input and mixed-output bundle of the Konami audio mixer.
// The driver of samples uses master; the mixer uses slave.
interface konami_audio_mixer_if #(
    parameter int CHANNELS = 4,
    parameter int IN_W     = 16,
    parameter int OUT_W    = 16
);
    logic                       sample_cen;
    logic [CHANNELS*IN_W-1:0]   ch_in;
    logic [CHANNELS*4-1:0]      ch_gain;
    logic [CHANNELS-1:0]        ch_invert;
    logic [CHANNELS-1:0]        ch_enable;
    logic                       pause;
    logic signed [OUT_W-1:0]    sound;
    logic                       sample_valid;
    logic                       clip;
    logic                       overrun;

    modport master (
        output sample_cen, ch_in, ch_gain, ch_invert, ch_enable, pause,
        input  sound, sample_valid, clip, overrun
    );

    modport slave (
        input  sample_cen, ch_in, ch_gain, ch_invert, ch_enable, pause,
        output sound, sample_valid, clip, overrun
    );
endinterface

// File: rtl/konami_mix_term.sv
// Combinational per-channel term: optional negation, enable gating and gain shift,
// sign-extended to the accumulator width.
import konami_audio_pkg::*;

module konami_mix_term #(
    parameter int IN_W  = 16,
    parameter int ACC_W = 26
) (
    input  logic signed [IN_W-1:0]  x,
    input  logic signed [3:0]       gain,
    input  logic                    invert,
    input  logic                    enable,
    output logic signed [ACC_W-1:0] term
);
    logic signed [IN_W:0] x_ext;
    logic signed [IN_W:0] x_sel;

    // One extra bit so that negating the most-negative sample stays exact.
    always_comb begin
        x_ext = {x[IN_W-1], x};
        x_sel = invert ? -x_ext : x_ext;
        term  = '0;
        if (enable) begin
            term = ACC_W'(gain_scale({{(SCALE_W-IN_W-1){x_sel[IN_W]}}, x_sel}, gain));
        end
    end

endmodule

// File: rtl/konami_audio_mixer.sv
// Time-multiplexed Konami sound mixer: one adder walks the snapshotted channels, then
// the sum is shifted, saturated, muted and registered. KONAMI_MIXER_SOFT_MUTE_EN selects a ramped mute.
import konami_audio_pkg::*;

module konami_audio_mixer #(
    parameter int CHANNELS  = 4,
    parameter int IN_W      = 16,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 0
) (
    input  logic               clk_49m,
    input  logic               reset,
    konami_audio_mixer_if.slave mix
);
    localparam int ACC_W = acc_width(IN_W, CHANNELS);
    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

    mix_state_t state_reg, state_next;

    logic [CHANNELS*IN_W-1:0] in_reg;
    logic [CHANNELS*4-1:0]    gain_reg;
    logic [CHANNELS-1:0]      inv_reg;
    logic [CHANNELS-1:0]      en_reg;
    logic                     pause_reg;
    logic                     snap;

    logic [IDX_W-1:0]         idx_reg, idx_next;
    logic signed [ACC_W-1:0]  acc_reg, acc_next;
    logic signed [OUT_W-1:0]  sound_reg, sound_next;
    logic                     valid_reg, valid_next;
    logic                     clip_reg, clip_next;
    logic                     overrun_reg, overrun_next;

    logic signed [IN_W-1:0]   in_arr   [CHANNELS];
    logic signed [3:0]        gain_arr [CHANNELS];
    logic signed [ACC_W-1:0]  term;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [OUT_W-1:0]  sat_val;
    logic                     sat_clip;
    logic signed [OUT_W-1:0]  muted;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_unpack
            assign in_arr[gi]   = in_reg[gi*IN_W +: IN_W];
            assign gain_arr[gi] = gain_reg[gi*4 +: 4];
        end
    endgenerate

    konami_mix_term #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_term (
        .x      (in_arr[idx_reg]),
        .gain   (gain_arr[idx_reg]),
        .invert (inv_reg[idx_reg]),
        .enable (en_reg[idx_reg]),
        .term   (term)
    );

    assign shifted = acc_reg >>> OUT_SHIFT;

    always_comb begin
        sat_t r;
        r        = saturate({{(SAT_W-ACC_W){shifted[ACC_W-1]}}, shifted}, OUT_W);
        sat_val  = OUT_W'(r.value);
        sat_clip = r.clip;
    end

`ifdef KONAMI_MIXER_SOFT_MUTE_EN
    logic [3:0] level_reg, level_step;

    // The level moves one step per output sample; the new level applies to that sample.
    always_comb begin
        level_step = level_reg;
        if (pause_reg) begin
            if (level_reg != 4'd15) level_step = level_reg + 4'd1;
        end else begin
            if (level_reg != 4'd0) level_step = level_reg - 4'd1;
        end
        muted = (level_step == 4'd15) ? '0 : (sat_val >>> level_step);
    end

    always_ff @(posedge clk_49m) begin
        if (reset) begin
            level_reg <= 4'd0;
        end else if (state_reg == OUT) begin
            level_reg <= level_step;
        end
    end
`else
    always_comb begin
        muted = pause_reg ? '0 : sat_val;
    end
`endif

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        acc_next     = acc_reg;
        sound_next   = sound_reg;
        valid_next   = 1'b0;
        clip_next    = clip_reg;
        overrun_next = overrun_reg | (mix.sample_cen && (state_reg != IDLE));
        snap         = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (mix.sample_cen) begin
                    snap       = 1'b1;
                    acc_next   = '0;
                    idx_next   = '0;
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                acc_next = acc_reg + term;
                idx_next = idx_reg + IDX_W'(1);
                if (idx_reg == LAST_IDX) state_next = OUT;
            end
            OUT: begin
                sound_next = muted;
                valid_next = 1'b1;
                clip_next  = clip_reg | sat_clip;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_49m) begin
        if (reset) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            acc_reg     <= '0;
            sound_reg   <= '0;
            valid_reg   <= 1'b0;
            clip_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            acc_reg     <= acc_next;
            sound_reg   <= sound_next;
            valid_reg   <= valid_next;
            clip_reg    <= clip_next;
            overrun_reg <= overrun_next;
        end
    end

    // Snapshot keeps the in-flight sample independent of later input changes.
    always_ff @(posedge clk_49m) begin
        if (reset) begin
            in_reg    <= '0;
            gain_reg  <= '0;
            inv_reg   <= '0;
            en_reg    <= '0;
            pause_reg <= 1'b0;
        end else if (snap) begin
            in_reg    <= mix.ch_in;
            gain_reg  <= mix.ch_gain;
            inv_reg   <= mix.ch_invert;
            en_reg    <= mix.ch_enable;
            pause_reg <= mix.pause;
        end
    end

    assign mix.sound        = sound_reg;
    assign mix.sample_valid = valid_reg;
    assign mix.clip         = clip_reg;
    assign mix.overrun      = overrun_reg;

endmodule

// File: tb/tb_konami_audio_mixer.sv
// Directed self-checking bench for konami_audio_mixer with two channels, 16-bit in/out.
// Follows KONAMI_MIXER_SOFT_MUTE_EN to pick the expected pause behaviour.
module tb_konami_audio_mixer;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    konami_audio_mixer_if #(.CHANNELS(2), .IN_W(16), .OUT_W(16)) mix ();

    konami_audio_mixer #(
        .CHANNELS  (2),
        .IN_W      (16),
        .OUT_W     (16),
        .OUT_SHIFT (0)
    ) dut (
        .clk_49m (clk),
        .reset   (reset),
        .mix     (mix)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input int x0, input int g0, input int x1, input int g1,
                         input logic [1:0] inv, input logic [1:0] en, input logic p);
        mix.ch_in     = {16'(x1), 16'(x0)};
        mix.ch_gain   = {4'(g1), 4'(g0)};
        mix.ch_invert = inv;
        mix.ch_enable = en;
        mix.pause     = p;
    endtask

    // Strobe for one cycle, then wait (bounded) for sample_valid; reports latency and pulse width.
    task automatic do_sample(input int x0, input int g0, input int x1, input int g1,
                             input logic [1:0] inv, input logic [1:0] en, input logic p,
                             output int lat, output logic signed [15:0] snd, output logic one_cycle);
        @(negedge clk);
        drive(x0, g0, x1, g1, inv, en, p);
        mix.sample_cen = 1'b1;
        @(negedge clk);
        mix.sample_cen = 1'b0;
        lat = 1;
        while (mix.sample_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        snd = mix.sound;
        @(negedge clk);
        one_cycle = (mix.sample_valid === 1'b0);
        $display("sample x0=%0d g0=%0d x1=%0d g1=%0d inv=%b en=%b pause=%b -> sound=%0d latency=%0d",
                 x0, g0, x1, g1, inv, en, p, snd, lat);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        mix.sample_cen = 1'b0;
        drive(0, 0, 0, 0, 2'b00, 2'b11, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (mix.sound !== 16'(0)) begin errors++; $display("FAIL reset_sound: got %0d want 0", mix.sound); end
        checks++; if (mix.sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", mix.sample_valid); end
        checks++; if (mix.clip !== 1'b0) begin errors++; $display("FAIL reset_clip: got %b want 0", mix.clip); end
        checks++; if (mix.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", mix.overrun); end
    endtask

    task automatic test_basic_mix;
        int lat; logic signed [15:0] snd; logic oc;
        do_sample(1000, 0, -200, 1, 2'b00, 2'b11, 1'b0, lat, snd, oc);
        checks++; if (snd !== 16'(600)) begin errors++; $display("FAIL basic_sound: got %0d want 600", snd); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d want 4", lat); end
        checks++; if (oc !== 1'b1) begin errors++; $display("FAIL basic_pulse_width: got %b want 1", oc); end
        checks++; if (mix.clip !== 1'b0) begin errors++; $display("FAIL basic_clip: got %b want 0", mix.clip); end
        drive(7, 0, 7, 0, 2'b00, 2'b11, 1'b0);
        repeat (5) @(negedge clk);
        checks++; if (mix.sound !== 16'(600)) begin errors++; $display("FAIL basic_hold: got %0d want 600", mix.sound); end
        do_sample(100, 7, -3, -2, 2'b00, 2'b11, 1'b0, lat, snd, oc);
        checks++; if (snd !== 16'(12799)) begin errors++; $display("FAIL gain_extremes: got %0d want 12799", snd); end
    endtask

    task automatic test_clip;
        int lat; logic signed [15:0] snd; logic oc;
        do_sample(30000, 0, 30000, 0, 2'b00, 2'b11, 1'b0, lat, snd, oc);
        checks++; if (snd !== 16'(32767)) begin errors++; $display("FAIL clip_pos_sound: got %0d want 32767", snd); end
        checks++; if (mix.clip !== 1'b1) begin errors++; $display("FAIL clip_pos_flag: got %b want 1", mix.clip); end
        do_sample(0, 0, 0, 0, 2'b00, 2'b11, 1'b0, lat, snd, oc);
        checks++; if (snd !== 16'(0)) begin errors++; $display("FAIL clip_zero_sound: got %0d want 0", snd); end
        checks++; if (mix.clip !== 1'b1) begin errors++; $display("FAIL clip_sticky: got %b want 1", mix.clip); end
        do_sample(-30000, 0, -30000, 0, 2'b00, 2'b11, 1'b0, lat, snd, oc);
        checks++; if (snd !== 16'(-32768)) begin errors++; $display("FAIL clip_neg_sound: got %0d want -32768", snd); end
    endtask

    task automatic test_invert_gain;
        int lat; logic signed [15:0] snd; logic oc;
        do_sample(-32768, 0, 12345, 0, 2'b01, 2'b01, 1'b0, lat, snd, oc);
        checks++; if (snd !== 16'(32767)) begin errors++; $display("FAIL invert_min: got %0d want 32767", snd); end
        checks++; if (mix.clip !== 1'b1) begin errors++; $display("FAIL invert_min_clip: got %b want 1", mix.clip); end
        do_sample(-7, -1, 12345, 0, 2'b00, 2'b01, 1'b0, lat, snd, oc);
        checks++; if (snd !== 16'(-4)) begin errors++; $display("FAIL neg_gain_round: got %0d want -4", snd); end
        do_sample(256, -8, -1, -8, 2'b00, 2'b11, 1'b0, lat, snd, oc);
        checks++; if (snd !== 16'(0)) begin errors++; $display("FAIL gain_min8: got %0d want 0", snd); end
        do_sample(500, 0, 300, 2, 2'b10, 2'b11, 1'b0, lat, snd, oc);
        checks++; if (snd !== 16'(-700)) begin errors++; $display("FAIL invert_ch1: got %0d want -700", snd); end
    endtask

    task automatic test_snapshot;
        int lat;
        @(negedge clk);
        drive(1000, 0, -200, 1, 2'b00, 2'b11, 1'b0);
        mix.sample_cen = 1'b1;
        @(negedge clk);
        mix.sample_cen = 1'b0;
        drive(5000, 3, 5000, 3, 2'b11, 2'b11, 1'b1);
        lat = 1;
        while (mix.sample_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        $display("sample snapshot test -> sound=%0d latency=%0d", mix.sound, lat);
        checks++; if (mix.sound !== 16'(600)) begin errors++; $display("FAIL snapshot_sound: got %0d want 600", mix.sound); end
        drive(0, 0, 0, 0, 2'b00, 2'b11, 1'b0);
    endtask

    task automatic test_overrun;
        int pulses;
        logic signed [15:0] first_snd;
        first_snd = 16'(0);
        pulses = 0;
        checks++; if (mix.overrun !== 1'b0) begin errors++; $display("FAIL overrun_before: got %b want 0", mix.overrun); end
        @(negedge clk);
        drive(2000, 0, 100, 0, 2'b00, 2'b11, 1'b0);
        mix.sample_cen = 1'b1;
        @(negedge clk);
        mix.sample_cen = 1'b0;
        @(negedge clk);
        drive(9000, 1, 9000, 1, 2'b00, 2'b11, 1'b0);
        mix.sample_cen = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            mix.sample_cen = 1'b0;
            if (mix.sample_valid === 1'b1) begin
                if (pulses == 0) first_snd = mix.sound;
                pulses++;
            end
        end
        $display("sample overrun test -> pulses=%0d sound=%0d", pulses, first_snd);
        checks++; if (pulses !== 1) begin errors++; $display("FAIL overrun_pulses: got %0d want 1", pulses); end
        checks++; if (first_snd !== 16'(2100)) begin errors++; $display("FAIL overrun_sound: got %0d want 2100", first_snd); end
        checks++; if (mix.overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b want 1", mix.overrun); end
    endtask

    task automatic test_reset_mid;
        int pulses; int lat; logic signed [15:0] snd; logic oc;
        pulses = 0;
        @(negedge clk);
        drive(3000, 0, 3000, 0, 2'b00, 2'b11, 1'b0);
        mix.sample_cen = 1'b1;
        @(negedge clk);
        mix.sample_cen = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (mix.sample_valid === 1'b1) pulses++;
            @(negedge clk);
        end
        $display("sample reset mid-accumulation -> pulses=%0d sound=%0d", pulses, mix.sound);
        checks++; if (pulses !== 0) begin errors++; $display("FAIL resetmid_pulses: got %0d want 0", pulses); end
        checks++; if (mix.sound !== 16'(0)) begin errors++; $display("FAIL resetmid_sound: got %0d want 0", mix.sound); end
        checks++; if (mix.clip !== 1'b0) begin errors++; $display("FAIL resetmid_clip: got %b want 0", mix.clip); end
        checks++; if (mix.overrun !== 1'b0) begin errors++; $display("FAIL resetmid_overrun: got %b want 0", mix.overrun); end
        do_sample(1000, 0, -200, 1, 2'b00, 2'b11, 1'b0, lat, snd, oc);
        checks++; if (snd !== 16'(600)) begin errors++; $display("FAIL resetmid_next: got %0d want 600", snd); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL resetmid_latency: got %0d want 4", lat); end
    endtask

    task automatic test_pause;
        int lat; logic signed [15:0] snd; logic oc;
        logic signed [15:0] want;
`ifdef KONAMI_MIXER_SOFT_MUTE_EN
        for (int k = 1; k <= 15; k++) begin
            do_sample(16384, 0, 0, 0, 2'b00, 2'b01, 1'b1, lat, snd, oc);
            want = (k == 15) ? 16'(0) : 16'(16384 >> k);
            checks++; if (snd !== want) begin errors++; $display("FAIL pause_ramp_down[%0d]: got %0d want %0d", k, snd, want); end
        end
        for (int k = 1; k <= 15; k++) begin
            do_sample(16384, 0, 0, 0, 2'b00, 2'b01, 1'b0, lat, snd, oc);
            want = 16'(16384 >> (15 - k));
            checks++; if (snd !== want) begin errors++; $display("FAIL pause_ramp_up[%0d]: got %0d want %0d", k, snd, want); end
        end
`else
        do_sample(16384, 0, 0, 0, 2'b00, 2'b01, 1'b1, lat, snd, oc);
        want = 16'(0);
        checks++; if (snd !== want) begin errors++; $display("FAIL pause_mute: got %0d want %0d", snd, want); end
        do_sample(16384, 0, 0, 0, 2'b00, 2'b01, 1'b0, lat, snd, oc);
        want = 16'(16384);
        checks++; if (snd !== want) begin errors++; $display("FAIL pause_release: got %0d want %0d", snd, want); end
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        mix.sample_cen = 1'b0;
        drive(0, 0, 0, 0, 2'b00, 2'b00, 1'b0);
        test_reset();
        test_basic_mix();
        test_snapshot();
        test_overrun();
        test_clip();
        test_invert_gain();
        test_reset_mid();
        test_pause();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/konami_audio_mixer.md
# konami_audio_mixer

Parametrised, time-multiplexed audio mixer for the Konami arcade PCB models. It replaces the fixed per-board shift, invert and sum sound expressions with one shared block. It sums up to `CHANNELS` signed sources with per-channel gain, phase inversion and enable, using one adder that steps through the channels. Each result is saturated and registered once per sample strobe, with pause muting, and drives the top-level `sound` output.

## Interface
Parameters:
- `CHANNELS`, 4: number of mixed sources, 1..8
- `IN_W`, 16: signed input sample width
- `OUT_W`, 16: signed output width
- `OUT_SHIFT`, 0: master arithmetic right shift applied before saturation, 0..7

Ports (one clock; reset is synchronous and active-high):
- `clk_49m`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `sample_cen`  in  1  one-cycle sample strobe
- `ch_in`  in  CHANNELS*IN_W  packed signed samples; channel k is at [k*IN_W +: IN_W]
- `ch_gain`  in  CHANNELS*4  packed signed gain codes, -8..7
- `ch_invert`  in  CHANNELS  1 = negate the channel
- `ch_enable`  in  CHANNELS  0 = channel contributes 0
- `pause`  in  1  mute request
- `sound`  out  OUT_W  registered signed mix
- `sample_valid`  out  1  one-cycle pulse when `sound` updates
- `clip`  out  1  sticky flag: saturation has occurred
- `overrun`  out  1  sticky flag: a `sample_cen` arrived while busy

## Operation
- States: IDLE, ACCUM, OUT.
- IDLE:
  - On `sample_cen`, snapshot `ch_in`, `ch_gain`, `ch_invert`, `ch_enable` and `pause`.
  - Clear the accumulator and set the channel index to 0. Go to ACCUM.
- ACCUM, one channel per cycle:
  - Term = enable ? scale(invert ? -x : x, g) : 0.
  - Negation is done at IN_W+1 bits, so negating the most-negative input is exact.
  - scale: g ≥ 0 gives x <<< g; g < 0 gives x >>> -g (arithmetic shift, rounds toward -inf).
  - Accumulator width is ACC_W = IN_W + 1 + 7 + clog2(CHANNELS). It never overflows internally.
  - After index CHANNELS-1, go to OUT.
- OUT:
  - v = acc >>> OUT_SHIFT.
  - Saturate v to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. If the value was clamped, set `clip`.
  - Apply the mute (see Configuration). Register the result to `sound` and pulse `sample_valid`. Return to IDLE.
- A `sample_cen` in ACCUM or OUT is ignored: no restart, no snapshot, and `overrun` is set. `sample_cen` arriving in the same cycle as the OUT→IDLE transition is also ignored.
- `clip` and `overrun` clear only on `reset`.
- Inputs that change after the snapshot do not affect the sample in progress.

## Timing
- Reset values: `sound` = 0, `sample_valid` = 0, `clip` = 0, `overrun` = 0, state IDLE, mute level 0.
- Latency: `sample_cen` at cycle t gives `sound`/`sample_valid` at cycle t+CHANNELS+2.
- Minimum strobe spacing is CHANNELS+2 cycles.
- `sound` holds its value between `sample_valid` pulses.
- Reset asserted mid-ACCUM or mid-OUT abandons the sample: no `sample_valid` pulse, and all outputs take their reset values on the next edge.

## Configuration
- `KONAMI_MIXER_SOFT_MUTE_EN` defined:
  - A 4-bit mute level is updated once per output sample. It increments toward 15 while the snapshotted `pause` is 1, and decrements toward 0 otherwise.
  - Output = sat >>> level. Level 15 forces exactly 0.
- Not defined:
  - The snapshotted `pause` = 1 forces the next output sample to 0.
  - No level register exists.

## Structure
- Package `konami_audio_pkg` holds:
  - the state enum `mix_state_t`
  - the localparam function for ACC_W
  - function `gain_scale` (gain decode and shift)
  - function `saturate` (parametrised clamp returning a value and a clip bit)
- One sub-module, `konami_mix_term`, is combinational. It performs invert, enable and scale for the selected channel.
- The mixer owns the FSM, snapshot registers, accumulator and mute logic.

## Test plan
Unless a scenario states otherwise, benches use CHANNELS=2, IN_W=16, OUT_W=16, OUT_SHIFT=0.
- ch0=1000, g=0; ch1=-200, g=1; both enabled; strobe at t → `sound`=600 and `sample_valid` high at t+4.
- ch0=ch1=30000, g=0 → `sound`=32767, `clip`=1; a later strobe with 0/0 → `sound`=0 and `clip` stays 1.
- ch0=-32768 inverted, ch1 disabled → `sound`=32767, `clip`=1; ch0=-7, g=-1 alone → `sound`=-4.
- Second strobe at t+2 → no extra `sample_valid` pulse, `overrun`=1, and the output equals the first sample's mix.
- Reset pulse at t+2 → no valid pulse; `sound`=0 and all flags 0; the next strobe mixes normally.
- `KONAMI_MIXER_SOFT_MUTE_EN`, ch0=16384, `pause`=1 → outputs 8192, 4096, …, then 0 at the 15th sample. `pause`=0 → the output ramps back to 16384 over 15 samples. Without the macro → 0 on the first paused sample.
